// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit and its datapath.
// CTRL_JAL_EN adds jal/jr decode; without it both decode as illegal.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
`ifdef CTRL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
`endif

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_4     = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_RS  = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_EXEC_R, S_EXEC_I,
    S_ALU_WB, S_BRANCH, S_JUMP
  } state_t;

  typedef enum logic [3:0] {
    I_LW, I_SW, I_ADDU, I_SUBU, I_ORI, I_LUI,
    I_BEQ, I_J, I_JAL, I_JR, I_BAD
  } instr_t;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       ir_wr;
    logic       rf_wr;
    logic       dm_wr;
    logic       ext_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] npc_op;
  } ctrl_t;

  function automatic instr_t classify(
    input logic [5:0] opcode,
    input logic [5:0] funct
  );
    instr_t r;
    r = I_BAD;
    unique case (opcode)
      OP_LW:  r = I_LW;
      OP_SW:  r = I_SW;
      OP_ORI: r = I_ORI;
      OP_LUI: r = I_LUI;
      OP_BEQ: r = I_BEQ;
      OP_J:   r = I_J;
`ifdef CTRL_JAL_EN
      OP_JAL: r = I_JAL;
`endif
      OP_RTYPE: begin
        if (funct == FN_ADDU)      r = I_ADDU;
        else if (funct == FN_SUBU) r = I_SUBU;
`ifdef CTRL_JAL_EN
        else if (funct == FN_JR)   r = I_JR;
`endif
        else                       r = I_BAD;
      end
      default: r = I_BAD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_ctrl_out.sv
// Moore control-vector decoder: state plus decoded instruction class.
// Reset forces every write enable and select to zero.
module mc_ctrl_out
  import mc_pkg::*;
(
  input  logic   rst,
  input  state_t state,
  input  instr_t instr,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          ctrl.ir_wr     = 1'b1;
          ctrl.pc_wr     = 1'b1;
          ctrl.alu_src_b = SRCB_4;
          ctrl.alu_op    = ALU_ADD;
          ctrl.npc_op    = NPC_SEQ;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_IMMSH;
          ctrl.ext_op    = 1'b1;
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.ext_op    = 1'b1;
        end
        S_MEM_RD: ;
        S_MEM_WB: begin
          ctrl.rf_wr      = 1'b1;
          ctrl.mem_to_reg = WB_MDR;
        end
        S_MEM_WR: ctrl.dm_wr = 1'b1;
        S_EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_RT;
          ctrl.alu_op = (instr == I_SUBU) ? ALU_SUB : ALU_ADD;
        end
        // ori/lui operate on rs, zero-extended imm
        S_EXEC_I: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op = (instr == I_LUI) ? ALU_LUI : ALU_OR;
        end
        S_ALU_WB: begin
          ctrl.rf_wr      = 1'b1;
          ctrl.mem_to_reg = WB_ALU;
          ctrl.reg_dst = (instr == I_ADDU || instr == I_SUBU)
                         ? DST_RD : DST_RT;
        end
        S_BRANCH: begin
          ctrl.alu_op     = ALU_SUB;
          ctrl.alu_src_a  = 1'b1;
          ctrl.pc_wr_cond = 1'b1;
          ctrl.npc_op     = NPC_BR;
        end
        S_JUMP: begin
          ctrl.pc_wr  = 1'b1;
          ctrl.npc_op = (instr == I_JR) ? NPC_RS : NPC_J;
          if (instr == I_JAL) begin
            ctrl.rf_wr      = 1'b1;
            ctrl.reg_dst    = DST_RA;
            ctrl.mem_to_reg = WB_PC;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: state register and next-state.
// Optional jal/jr sequencing is enabled with CTRL_JAL_EN.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       PCWrCond,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic       ExtOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] NPCOp,
  output logic       illegal
);

  state_t state, state_nx;
  instr_t instr;
  ctrl_t  ctrl;
  logic   illegal_q;

  // zero is consumed by the datapath's PCWrCond gate, not here
  logic unused_zero;
  assign unused_zero = zero;

  assign instr = classify(opcode, funct);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE && instr == I_BAD)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx = S_FETCH;
    unique case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        unique case (instr)
          I_LW, I_SW:     state_nx = S_MEM_ADDR;
          I_ADDU, I_SUBU: state_nx = S_EXEC_R;
          I_ORI, I_LUI:   state_nx = S_EXEC_I;
          I_BEQ:          state_nx = S_BRANCH;
          I_J, I_JAL,
          I_JR:           state_nx = S_JUMP;
          default:        state_nx = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_nx = (instr == I_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_nx = S_MEM_WB;
      S_EXEC_R: state_nx = S_ALU_WB;
      S_EXEC_I: state_nx = S_ALU_WB;
      default:  state_nx = S_FETCH;
    endcase
  end

  mc_ctrl_out u_out (
    .rst   (rst),
    .state (state),
    .instr (instr),
    .ctrl  (ctrl)
  );

  assign PCWr     = ctrl.pc_wr;
  assign PCWrCond = ctrl.pc_wr_cond;
  assign IRWr     = ctrl.ir_wr;
  assign RFWr     = ctrl.rf_wr;
  assign DMWr     = ctrl.dm_wr;
  assign ExtOp    = ctrl.ext_op;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign NPCOp    = ctrl.npc_op;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction microprogram model, one compare
// process at negedge, plus literal pins of the model and DUT.
module tb_mc_ctrl;

`ifdef CTRL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       PCWr, PCWrCond, IRWr, RFWr, DMWr, ExtOp, ALUSrcA;
  logic [1:0] ALUSrcB, RegDst, MemtoReg, NPCOp;
  logic [2:0] ALUOp;
  logic       illegal;

  typedef logic [17:0] vec_t;

  int    checks = 0;
  int    failures = 0;
  bit    exp_on = 1'b0;
  vec_t  exp_vec;
  logic  exp_ill;
  string tag = "";
  vec_t  prog[$];
  bit    prog_bad;
  bit    m_ill;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero(zero), .PCWr(PCWr), .PCWrCond(PCWrCond), .IRWr(IRWr),
    .RFWr(RFWr), .DMWr(DMWr), .ExtOp(ExtOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .NPCOp(NPCOp), .illegal(illegal)
  );

  wire vec_t dut_vec = {PCWr, PCWrCond, IRWr, RFWr, DMWr, ExtOp,
                        ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg,
                        NPCOp};

  function automatic vec_t mk(
    input bit pcw, pcc, ir, rf, dm, ext, sa,
    input logic [1:0] sb, input logic [2:0] op,
    input logic [1:0] rd, mr, np);
    return {pcw, pcc, ir, rf, dm, ext, sa, sb, op, rd, mr, np};
  endfunction

  // Microprogram per instruction, straight from the operation rules.
  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    vec_t f, d, ma;
    f  = mk(1,0,1,0,0,0,0,2'd1,3'd0,2'd0,2'd0,2'd0);
    d  = mk(0,0,0,0,0,1,0,2'd3,3'd0,2'd0,2'd0,2'd0);
    ma = mk(0,0,0,0,0,1,1,2'd2,3'd0,2'd0,2'd0,2'd0);
    prog = {f, d};
    prog_bad = 1'b0;
    if (op == 6'b100011) begin
      prog.push_back(ma);
      prog.push_back('0);
      prog.push_back(mk(0,0,0,1,0,0,0,2'd0,3'd0,2'd0,2'd1,2'd0));
    end else if (op == 6'b101011) begin
      prog.push_back(ma);
      prog.push_back(mk(0,0,0,0,1,0,0,2'd0,3'd0,2'd0,2'd0,2'd0));
    end else if (op == 6'b000000 &&
                 (fn == 6'b100001 || fn == 6'b100011)) begin
      prog.push_back(mk(0,0,0,0,0,0,1,2'd0,
                        (fn == 6'b100011) ? 3'd1 : 3'd0,
                        2'd0,2'd0,2'd0));
      prog.push_back(mk(0,0,0,1,0,0,0,2'd0,3'd0,2'd1,2'd0,2'd0));
    end else if (op == 6'b001101 || op == 6'b001111) begin
      prog.push_back(mk(0,0,0,0,0,0,1,2'd2,
                        (op == 6'b001111) ? 3'd3 : 3'd2,
                        2'd0,2'd0,2'd0));
      prog.push_back(mk(0,0,0,1,0,0,0,2'd0,3'd0,2'd0,2'd0,2'd0));
    end else if (op == 6'b000100) begin
      prog.push_back(mk(0,1,0,0,0,0,1,2'd0,3'd1,2'd0,2'd0,2'd1));
    end else if (op == 6'b000010) begin
      prog.push_back(mk(1,0,0,0,0,0,0,2'd0,3'd0,2'd0,2'd0,2'd2));
    end else if (JAL_EN && op == 6'b000011) begin
      prog.push_back(mk(1,0,0,1,0,0,0,2'd0,3'd0,2'd2,2'd2,2'd2));
    end else if (JAL_EN && op == 6'b000000 && fn == 6'b001000) begin
      prog.push_back(mk(1,0,0,0,0,0,0,2'd0,3'd0,2'd0,2'd0,2'd3));
    end else begin
      prog_bad = 1'b1;
    end
  endtask

  task automatic pin(input string n, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      checks++;
      if (dut_vec !== exp_vec || illegal !== exp_ill) begin
        failures++;
        $display("FAIL %s actual=%b ill=%b required=%b ill=%b",
                 tag, dut_vec, illegal, exp_vec, exp_ill);
      end
    end
  end

  // Called at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input string n, input logic [5:0] op,
                           input logic [5:0] fn, input logic z,
                           input int lim);
    build(op, fn);
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int k = 0; k < prog.size() && k < lim; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      tag     = $sformatf("%s_c%0d", n, k + 1);
      exp_vec = prog[k];
      exp_ill = m_ill;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (prog_bad && lim >= prog.size()) m_ill = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    m_ill = 1'b0;

    build(6'b100011, 6'd0);
    pin("cpi_lw", prog.size(), 5);
    pin("lw_fetch", prog[0], 18'b1010_000_01_000_00_00_00);
    pin("lw_wb", prog[4], 18'b0001_000_00_000_00_01_00);
    build(6'b101011, 6'd0);
    pin("cpi_sw", prog.size(), 4);
    build(6'b000100, 6'd0);
    pin("cpi_beq", prog.size(), 3);
    pin("beq_c3", prog[2], 18'b0100_001_00_001_00_00_01);
    build(6'b111111, 6'd0);
    pin("cpi_bad", prog.size(), 2);
    build(6'b000011, 6'd0);
    if (JAL_EN)
      pin("jal_c3", prog[2], 18'b1001_000_00_000_10_10_10);
    else
      pin("jal_bad", prog.size(), 2);

    repeat (3) begin
      @(posedge clk);
      #1;
      tag = "reset";
      exp_vec = '0;
      exp_ill = 1'b0;
      exp_on = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr("lw",   6'b100011, 6'b000000, 1'b0, 99);
    run_instr("sw",   6'b101011, 6'b000000, 1'b0, 99);
    run_instr("addu", 6'b000000, 6'b100001, 1'b0, 99);
    run_instr("subu", 6'b000000, 6'b100011, 1'b0, 99);
    run_instr("ori",  6'b001101, 6'b000000, 1'b0, 99);
    run_instr("lui",  6'b001111, 6'b000000, 1'b0, 99);
    run_instr("beqz1", 6'b000100, 6'b000000, 1'b1, 99);
    run_instr("beqz0", 6'b000100, 6'b000000, 1'b0, 99);
    run_instr("j",    6'b000010, 6'b000000, 1'b0, 99);
    run_instr("jal",  6'b000011, 6'b000000, 1'b0, 99);
    run_instr("jr",   6'b000000, 6'b001000, 1'b0, 99);
    run_instr("bad",  6'b111111, 6'b000000, 1'b0, 99);
    pin("illegal_set", illegal, 1);
    run_instr("badfn", 6'b000000, 6'b000000, 1'b0, 99);
    run_instr("addu2", 6'b000000, 6'b100001, 1'b0, 99);
    pin("illegal_sticky", illegal, 1);

    run_instr("lw_abort", 6'b100011, 6'b000000, 1'b0, 4);
    rst = 1'b1;
    tag = "abort_rst";
    exp_vec = '0;
    exp_ill = m_ill;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ill = 1'b0;
    pin("illegal_clear", illegal, 0);
    run_instr("ori2", 6'b001101, 6'b000000, 1'b0, 99);

    exp_on = 1'b0;
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
